// File: rtl/pmp_pkg.sv
// Purpose : shared PMP constants, cfg-byte field positions and WARL helpers.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: CSR base addresses, A-field encodings, cfg bit positions,
//           cfg byte legalisation, entry-to-pmpcfg index mapping.
package pmp_pkg;

  localparam logic [11:0] PMPCFG_BASE   = 12'h3A0;
  localparam logic [11:0] PMPADDR_BASE  = 12'h3B0;
  localparam int          PMPADDR_COUNT = 64;

  // Address-matching mode held in cfg bits 4:3.
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } pmp_a_e;

  // Bit positions inside one cfg byte.
  localparam int CFG_L    = 7;
  localparam int CFG_A_HI = 4;
  localparam int CFG_A_LO = 3;
  localparam int CFG_X    = 2;
  localparam int CFG_W    = 1;
  localparam int CFG_R    = 0;

  // Bits that are actually stored; bits 6:5 are hardwired to zero.
  localparam logic [7:0] CFG_STORED_MASK =
    8'((1 << CFG_L) | (3 << CFG_A_LO) | (1 << CFG_X) | (1 << CFG_W) | (1 << CFG_R));

  // R=0/W=1 is a reserved combination: the whole byte keeps its old value.
  function automatic logic [7:0] cfg_legalize(input logic [7:0] old_cfg,
                                              input logic [7:0] new_cfg);
    if (!new_cfg[CFG_R] && new_cfg[CFG_W]) return old_cfg;
    return new_cfg & CFG_STORED_MASK;
  endfunction

  // A locked TOR entry also protects the pmpaddr of the entry below it.
  function automatic logic locked_tor(input logic [7:0] cfg);
    return cfg[CFG_L] && (cfg[CFG_A_HI:CFG_A_LO] == TOR);
  endfunction

  // pmpcfg CSR number holding a given entry. RV64 packs 8 entries per CSR
  // and only uses even CSR numbers, hence the xlen/32 stride.
  function automatic logic [3:0] cfg_csr_index(input int entry, input int xlen);
    return 4'((entry / (xlen / 8)) * (xlen / 32));
  endfunction

endpackage

// File: rtl/pmp_csr_bank_if.sv
// Purpose : privileged CSR access port into the PMP register bank.
// Latency : read data and illegal flag are combinational; writes commit on clk.
// Backpressure: none; one access per cycle is always accepted.
// Signals : CSRReadM/CSRWriteM strobes, CSRAdrM address, CSRWriteValM data in,
//           CSRReadValM data out, IllegalAccessM access fault.
interface pmp_csr_bank_if #(
  parameter int XLEN = 64
);

  logic            CSRReadM;
  logic            CSRWriteM;
  logic [11:0]     CSRAdrM;
  logic [XLEN-1:0] CSRWriteValM;
  logic [XLEN-1:0] CSRReadValM;
  logic            IllegalAccessM;

  modport master (
    output CSRReadM, CSRWriteM, CSRAdrM, CSRWriteValM,
    input  CSRReadValM, IllegalAccessM
  );

  modport slave (
    input  CSRReadM, CSRWriteM, CSRAdrM, CSRWriteValM,
    output CSRReadValM, IllegalAccessM
  );

endinterface

// File: rtl/pmp_entry_reg.sv
// Purpose : one PMP entry: cfg byte + pmpaddr register with WARL and lock gating.
// Latency : stored values update one clk after the write enable.
// Backpressure: none; ignored writes are silently dropped.
// Ports   : clk, reset; cfg_we/addr_we write enables; cfg_wdat/addr_wdat new
//           values; next_locked_tor from entry i+1; cfg/addr stored state;
//           changed = this cycle's write alters a stored bit.
module pmp_entry_reg
  import pmp_pkg::*;
#(
  parameter int PA_BITS = 56
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic               addr_we,
  input  logic [7:0]         cfg_wdat,
  input  logic [PA_BITS-3:0] addr_wdat,
  input  logic               next_locked_tor,
  output logic [7:0]         cfg,
  output logic [PA_BITS-3:0] addr,
  output logic               changed
);

  logic               cfg_upd;
  logic               addr_upd;
  logic [7:0]         cfg_d;
  logic [PA_BITS-3:0] addr_d;

  // Locks are judged on the current (pre-write) state only.
  always_comb begin
    cfg_upd  = cfg_we && !cfg[CFG_L];
    addr_upd = addr_we && !cfg[CFG_L] && !next_locked_tor;
    cfg_d    = cfg_upd ? cfg_legalize(cfg, cfg_wdat) : cfg;
    addr_d   = addr_upd ? addr_wdat : addr;
    changed  = (cfg_d != cfg) || (addr_d != addr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg  <= '0;
      addr <= '0;
    end else begin
      cfg  <= cfg_d;
      addr <= addr_d;
    end
  end

endmodule

// File: rtl/pmp_csr_bank.sv
// Purpose : PMP configuration bank: pmpcfg/pmpaddr CSRs feeding the PMP checker.
// Latency : CSR reads combinational (read-before-write); writes visible next cycle.
// Backpressure: none; illegal or locked writes are dropped without stalling.
// Ports   : clk, reset; csr (slave CSR port); PMPCfg flattened cfg bytes;
//           PMPAdr flattened zero-extended pmpaddr; PMPUpdatedM one-cycle
//           pulse after any write that changed stored state.
module pmp_csr_bank
  import pmp_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int PA_BITS     = 56,
  parameter int PMP_ENTRIES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  pmp_csr_bank_if.slave                 csr,
  output logic [8*PMP_ENTRIES-1:0]      PMPCfg,
  output logic [XLEN*PMP_ENTRIES-1:0]   PMPAdr,
  output logic                          PMPUpdatedM
);

  localparam int BYTES_PER_CSR = XLEN / 8;
  localparam int ABITS         = PA_BITS - 2;
  // Storage is sized to at least one entry so zero-entry builds still elaborate.
  localparam int NE            = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1;

  logic               access;
  logic               cfg_sel;
  logic               addr_sel;
  logic               illegal;
  logic [11:0]        addr_idx;
  logic [XLEN-1:0]    rdata;

  logic [NE-1:0][7:0]       cfg_q;
  logic [NE-1:0][ABITS-1:0] addr_q;
  logic [NE-1:0]            changed;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign access   = csr.CSRReadM | csr.CSRWriteM;
  assign cfg_sel  = (csr.CSRAdrM[11:4] == PMPCFG_BASE[11:4]);
  assign addr_idx = csr.CSRAdrM - PMPADDR_BASE;
  assign addr_sel = (csr.CSRAdrM >= PMPADDR_BASE) && (addr_idx < 12'(PMPADDR_COUNT));

  // Odd pmpcfg numbers do not exist on RV64.
  assign illegal  = access && (XLEN == 64) && cfg_sel && csr.CSRAdrM[0];

  assign csr.IllegalAccessM = illegal;

  // ---------------------------------------------------------------------------
  // Entries
  // ---------------------------------------------------------------------------
  if (PMP_ENTRIES > 0) begin : g_entries
    for (genvar i = 0; i < PMP_ENTRIES; i++) begin : g_entry
      localparam int BYTE_POS = i % BYTES_PER_CSR;

      logic cfg_we;
      logic addr_we;
      logic next_lt;

      assign cfg_we  = csr.CSRWriteM && cfg_sel && !illegal &&
                       (csr.CSRAdrM[3:0] == cfg_csr_index(i, XLEN));
      assign addr_we = csr.CSRWriteM && addr_sel && (addr_idx == 12'(i));

      // The topmost entry has no neighbour above that could lock it.
      if (i + 1 < PMP_ENTRIES) begin : g_next
        assign next_lt = locked_tor(cfg_q[i+1]);
      end else begin : g_last
        assign next_lt = 1'b0;
      end

      pmp_entry_reg #(
        .PA_BITS(PA_BITS)
      ) u_entry (
        .clk             (clk),
        .reset           (reset),
        .cfg_we          (cfg_we),
        .addr_we         (addr_we),
        .cfg_wdat        (csr.CSRWriteValM[8*BYTE_POS +: 8]),
        .addr_wdat       (csr.CSRWriteValM[ABITS-1:0]),
        .next_locked_tor (next_lt),
        .cfg             (cfg_q[i]),
        .addr            (addr_q[i]),
        .changed         (changed[i])
      );

      assign PMPCfg[8*i +: 8]       = cfg_q[i];
      assign PMPAdr[XLEN*i +: XLEN] = XLEN'(addr_q[i]);
    end
  end else begin : g_none
    assign cfg_q   = '0;
    assign addr_q  = '0;
    assign changed = '0;
    assign PMPCfg  = '0;
    assign PMPAdr  = '0;
  end

  // ---------------------------------------------------------------------------
  // Read mux: sourced from registered state, so a same-cycle write is not seen.
  // Unimplemented entries simply never match and read as zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (!illegal) begin
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        if (cfg_sel && (csr.CSRAdrM[3:0] == cfg_csr_index(i, XLEN))) begin
          rdata[8*(i % BYTES_PER_CSR) +: 8] = cfg_q[i];
        end
        if (addr_sel && (addr_idx == 12'(i))) begin
          rdata = XLEN'(addr_q[i]);
        end
      end
    end
  end

  assign csr.CSRReadValM = rdata;

  // ---------------------------------------------------------------------------
  // Update pulse: high for exactly the cycle in which the new state is visible.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PMPUpdatedM <= 1'b0;
    end else begin
      PMPUpdatedM <= |changed;
    end
  end

endmodule

// File: tb/tb_pmp_csr_bank.sv
// Purpose : self-checking bench for pmp_csr_bank (XLEN=64, 16 entries).
// Latency : n/a.
// Backpressure: n/a.
module tb_pmp_csr_bank;

  localparam int XLEN    = 64;
  localparam int PA_BITS = 56;
  localparam int NE      = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pmp_csr_bank_if #(.XLEN(XLEN)) bus ();

  logic [8*NE-1:0]    PMPCfg;
  logic [XLEN*NE-1:0] PMPAdr;
  logic               PMPUpdatedM;

  pmp_csr_bank #(
    .XLEN        (XLEN),
    .PA_BITS     (PA_BITS),
    .PMP_ENTRIES (NE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .csr         (bus),
    .PMPCfg      (PMPCfg),
    .PMPAdr      (PMPAdr),
    .PMPUpdatedM (PMPUpdatedM)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: architectural view of the PMP CSRs.
  logic [7:0]         m_cfg [NE];
  logic [PA_BITS-3:0] m_adr [NE];
  bit                 m_changed;

  task automatic m_reset();
    for (int e = 0; e < NE; e++) begin
      m_cfg[e] = 8'h00;
      m_adr[e] = '0;
    end
  endtask

  task automatic m_write(input logic [11:0] a, input logic [63:0] v, output bit chg);
    int k, e;
    logic [7:0] nb;
    bit lck;
    chg = 0;
    if (a >= 12'h3A0 && a <= 12'h3AF) begin
      k = int'(a - 12'h3A0);
      if (k % 2 == 0) begin
        for (int j = 0; j < 8; j++) begin
          e  = 4 * k + j;
          nb = v[8*j +: 8];
          if (e < NE && !m_cfg[e][7] && !(nb[0] == 1'b0 && nb[1] == 1'b1)) begin
            nb[6:5] = 2'b00;
            if (nb != m_cfg[e]) chg = 1;
            m_cfg[e] = nb;
          end
        end
      end
    end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
      e = int'(a - 12'h3B0);
      if (e < NE) begin
        lck = m_cfg[e][7];
        if (e + 1 < NE) begin
          if (m_cfg[e+1][7] && m_cfg[e+1][4:3] == 2'b01) lck = 1;
        end
        if (!lck) begin
          if (v[PA_BITS-3:0] != m_adr[e]) chg = 1;
          m_adr[e] = v[PA_BITS-3:0];
        end
      end
    end
  endtask

  function automatic logic [63:0] m_read(input logic [11:0] a);
    logic [63:0] r;
    int k, e;
    r = '0;
    if (a >= 12'h3A0 && a <= 12'h3AF) begin
      k = int'(a - 12'h3A0);
      if (k % 2 == 0) begin
        for (int j = 0; j < 8; j++) begin
          e = 4 * k + j;
          if (e < NE) r[8*j +: 8] = m_cfg[e];
        end
      end
    end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
      e = int'(a - 12'h3B0);
      if (e < NE) r = {10'b0, m_adr[e]};
    end
    return r;
  endfunction

  function automatic bit m_illegal(input bit rd, input bit wr, input logic [11:0] a);
    return (rd || wr) && (a >= 12'h3A0) && (a <= 12'h3AF) && a[0];
  endfunction

  function automatic logic [8*NE-1:0] m_cfg_bus();
    logic [8*NE-1:0] b;
    for (int e = 0; e < NE; e++) b[8*e +: 8] = m_cfg[e];
    return b;
  endfunction

  function automatic logic [XLEN*NE-1:0] m_adr_bus();
    logic [XLEN*NE-1:0] b;
    for (int e = 0; e < NE; e++) b[XLEN*e +: XLEN] = {10'b0, m_adr[e]};
    return b;
  endfunction

  // One access cycle; returns at the falling edge after the commit edge.
  task automatic csr_op(input bit rd, input bit wr, input logic [11:0] a,
                        input logic [63:0] v, output logic [63:0] rv, output bit ill);
    @(negedge clk);
    bus.CSRReadM     = rd;
    bus.CSRWriteM    = wr;
    bus.CSRAdrM      = a;
    bus.CSRWriteValM = v;
    #1;
    rv  = bus.CSRReadValM;
    ill = bus.IllegalAccessM;
    if (wr) m_write(a, v, m_changed);
    else    m_changed = 0;
    @(negedge clk);
    bus.CSRReadM  = 1'b0;
    bus.CSRWriteM = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (PMPCfg !== '0) $display("FAIL reset_cfg: got %h want 0", PMPCfg); else passed++;
    checks++; if (PMPAdr !== '0) $display("FAIL reset_adr: got %h want 0", PMPAdr); else passed++;
    checks++; if (PMPUpdatedM !== 1'b0) $display("FAIL reset_upd: got %b want 0", PMPUpdatedM); else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_addr_write();
    logic [63:0] rv;
    bit ill;
    csr_op(0, 1, 12'h3B3, 64'h1000, rv, ill);
    checks++; if (PMPAdr[64*3 +: 64] !== 64'h1000) $display("FAIL addr3_write: got %h want 1000", PMPAdr[64*3 +: 64]); else passed++;
    checks++; if (PMPUpdatedM !== 1'b1) $display("FAIL addr3_pulse: got %b want 1", PMPUpdatedM); else passed++;
    @(negedge clk);
    checks++; if (PMPUpdatedM !== 1'b0) $display("FAIL addr3_pulse_end: got %b want 0", PMPUpdatedM); else passed++;
    // Reset lands mid-cycle while a fresh update pulse is high.
    bus.CSRWriteM = 1'b1; bus.CSRAdrM = 12'h3B3; bus.CSRWriteValM = 64'h2000;
    @(negedge clk);
    bus.CSRWriteM = 1'b0;
    checks++; if (PMPUpdatedM !== 1'b1) $display("FAIL addr3_pulse2: got %b want 1", PMPUpdatedM); else passed++;
    #2 reset = 1'b1;
    #1;
    checks++; if (PMPAdr !== '0) $display("FAIL async_reset_adr: got %h want 0", PMPAdr); else passed++;
    checks++; if (PMPUpdatedM !== 1'b0) $display("FAIL async_reset_upd: got %b want 0", PMPUpdatedM); else passed++;
    // A write under reset must be lost.
    @(negedge clk);
    bus.CSRWriteM = 1'b1; bus.CSRAdrM = 12'h3B1; bus.CSRWriteValM = 64'h55;
    @(negedge clk);
    bus.CSRWriteM = 1'b0;
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    checks++; if (PMPAdr !== '0) $display("FAIL write_in_reset: got %h want 0", PMPAdr); else passed++;
    checks++; if (PMPUpdatedM !== 1'b0) $display("FAIL write_in_reset_upd: got %b want 0", PMPUpdatedM); else passed++;
  endtask

  task automatic test_cfg_warl();
    logic [63:0] rv;
    bit ill;
    do_reset();
    csr_op(0, 1, 12'h3A0, 64'h0000_0000_8F00_0F1F, rv, ill);
    checks++; if (PMPCfg[63:0] !== 64'h0000_0000_8F00_0F1F) $display("FAIL cfg0_write: got %h want 8f000f1f", PMPCfg[63:0]); else passed++;
    checks++; if (PMPUpdatedM !== 1'b1) $display("FAIL cfg0_pulse: got %b want 1", PMPUpdatedM); else passed++;
    csr_op(0, 1, 12'h3A0, 64'h0, rv, ill);
    checks++; if (PMPCfg[63:0] !== 64'h0000_0000_8F00_0000) $display("FAIL cfg0_locked_keep: got %h want 8f000000", PMPCfg[63:0]); else passed++;
    csr_op(1, 0, 12'h3A0, 64'h0, rv, ill);
    checks++; if (rv !== 64'h0000_0000_8F00_0000) $display("FAIL cfg0_read: got %h want 8f000000", rv); else passed++;
    // Reserved R=0/W=1 pattern on entry 8 (pmpcfg2 byte 0).
    csr_op(0, 1, 12'h3A2, 64'h01, rv, ill);
    checks++; if (PMPCfg[71:64] !== 8'h01) $display("FAIL cfg8_init: got %h want 01", PMPCfg[71:64]); else passed++;
    csr_op(0, 1, 12'h3A2, 64'h62, rv, ill);
    checks++; if (PMPCfg[71:64] !== 8'h01) $display("FAIL cfg8_reserved: got %h want 01", PMPCfg[71:64]); else passed++;
    checks++; if (PMPUpdatedM !== 1'b0) $display("FAIL cfg8_reserved_pulse: got %b want 0", PMPUpdatedM); else passed++;
    csr_op(0, 1, 12'h3A2, 64'h63, rv, ill);
    checks++; if (PMPCfg[71:64] !== 8'h03) $display("FAIL cfg8_mask65: got %h want 03", PMPCfg[71:64]); else passed++;
  endtask

  task automatic test_lock_tor();
    logic [63:0] rv;
    bit ill;
    do_reset();
    csr_op(0, 1, 12'h3A0, 64'h0000_8900_0000_0000, rv, ill);
    checks++; if (PMPCfg[47:40] !== 8'h89) $display("FAIL cfg5_set: got %h want 89", PMPCfg[47:40]); else passed++;
    csr_op(0, 1, 12'h3B4, 64'hABC, rv, ill);
    checks++; if (PMPAdr[64*4 +: 64] !== 64'h0) $display("FAIL addr4_tor_locked: got %h want 0", PMPAdr[64*4 +: 64]); else passed++;
    checks++; if (PMPUpdatedM !== 1'b0) $display("FAIL addr4_no_pulse: got %b want 0", PMPUpdatedM); else passed++;
    csr_op(0, 1, 12'h3B5, 64'h77, rv, ill);
    checks++; if (PMPAdr[64*5 +: 64] !== 64'h0) $display("FAIL addr5_self_locked: got %h want 0", PMPAdr[64*5 +: 64]); else passed++;
    csr_op(0, 1, 12'h3B6, 64'hABC, rv, ill);
    checks++; if (PMPAdr[64*6 +: 64] !== 64'hABC) $display("FAIL addr6_open: got %h want abc", PMPAdr[64*6 +: 64]); else passed++;
    checks++; if (PMPUpdatedM !== 1'b1) $display("FAIL addr6_pulse: got %b want 1", PMPUpdatedM); else passed++;
    csr_op(0, 1, 12'h3A0, 64'h0, rv, ill);
    checks++; if (PMPCfg[47:40] !== 8'h89) $display("FAIL lock_sticky: got %h want 89", PMPCfg[47:40]); else passed++;
  endtask

  task automatic test_illegal();
    logic [63:0] rv;
    bit ill;
    do_reset();
    csr_op(0, 1, 12'h3A0, 64'h0101, rv, ill);
    csr_op(1, 0, 12'h3A1, 64'h0, rv, ill);
    checks++; if (ill !== 1'b1) $display("FAIL odd_cfg_read_ill: got %b want 1", ill); else passed++;
    checks++; if (rv !== 64'h0) $display("FAIL odd_cfg_read_val: got %h want 0", rv); else passed++;
    csr_op(0, 1, 12'h3A1, '1, rv, ill);
    checks++; if (ill !== 1'b1) $display("FAIL odd_cfg_write_ill: got %b want 1", ill); else passed++;
    checks++; if (PMPCfg !== m_cfg_bus()) $display("FAIL odd_cfg_state: got %h want %h", PMPCfg, m_cfg_bus()); else passed++;
    checks++; if (PMPUpdatedM !== 1'b0) $display("FAIL odd_cfg_pulse: got %b want 0", PMPUpdatedM); else passed++;
    csr_op(0, 0, 12'h3A1, 64'h0, rv, ill);
    checks++; if (ill !== 1'b0) $display("FAIL odd_cfg_idle_ill: got %b want 0", ill); else passed++;
    csr_op(1, 1, 12'h3EF, '1, rv, ill);
    checks++; if (rv !== 64'h0) $display("FAIL unimpl_read: got %h want 0", rv); else passed++;
    checks++; if (ill !== 1'b0) $display("FAIL unimpl_ill: got %b want 0", ill); else passed++;
    checks++; if (PMPUpdatedM !== 1'b0) $display("FAIL unimpl_pulse: got %b want 0", PMPUpdatedM); else passed++;
    checks++; if (PMPAdr !== m_adr_bus()) $display("FAIL unimpl_state: got %h want %h", PMPAdr, m_adr_bus()); else passed++;
  endtask

  task automatic test_addr_mask_rbw();
    logic [63:0] rv;
    bit ill;
    do_reset();
    csr_op(0, 1, 12'h3B0, '1, rv, ill);
    checks++; if (PMPAdr[63:0] !== 64'h003F_FFFF_FFFF_FFFF) $display("FAIL addr0_mask: got %h want 003fffffffffffff", PMPAdr[63:0]); else passed++;
    csr_op(1, 1, 12'h3B0, 64'h123, rv, ill);
    checks++; if (rv !== 64'h003F_FFFF_FFFF_FFFF) $display("FAIL addr0_rbw: got %h want 003fffffffffffff", rv); else passed++;
    checks++; if (PMPAdr[63:0] !== 64'h123) $display("FAIL addr0_new: got %h want 123", PMPAdr[63:0]); else passed++;
    csr_op(1, 0, 12'h3B0, 64'h0, rv, ill);
    checks++; if (rv !== 64'h123) $display("FAIL addr0_readback: got %h want 123", rv); else passed++;
  endtask

  // Back-to-back random accesses against the model, with one reset midway.
  task automatic test_random();
    logic [11:0] a;
    logic [63:0] v;
    bit rd, wr, chg;
    int r;
    do_reset();
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        bus.CSRReadM = 1'b0; bus.CSRWriteM = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
      end
      r = $urandom_range(0, 9);
      if (r < 4)      a = 12'h3A0 + 12'($urandom_range(0, 15));
      else if (r < 9) a = 12'h3B0 + 12'($urandom_range(0, 19));
      else            a = 12'($urandom_range(12'h390, 12'h3FF));
      v = {$urandom, $urandom};
      if (a >= 12'h3A0 && a <= 12'h3AF) begin
        for (int j = 0; j < 8; j++) if ($urandom_range(0, 15) != 0) v[8*j+7] = 1'b0;
      end
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) != 0);
      bus.CSRReadM = rd; bus.CSRWriteM = wr; bus.CSRAdrM = a; bus.CSRWriteValM = v;
      #1;
      checks++; if (bus.CSRReadValM !== m_read(a)) $display("FAIL rnd_read a=%h: got %h want %h", a, bus.CSRReadValM, m_read(a)); else passed++;
      checks++; if (bus.IllegalAccessM !== m_illegal(rd, wr, a)) $display("FAIL rnd_ill a=%h: got %b want %b", a, bus.IllegalAccessM, m_illegal(rd, wr, a)); else passed++;
      chg = 0;
      if (wr) m_write(a, v, chg);
      @(negedge clk);
      checks++; if (PMPUpdatedM !== chg) $display("FAIL rnd_pulse a=%h: got %b want %b", a, PMPUpdatedM, chg); else passed++;
      checks++; if (PMPCfg !== m_cfg_bus()) $display("FAIL rnd_cfg a=%h: got %h want %h", a, PMPCfg, m_cfg_bus()); else passed++;
      checks++; if (PMPAdr !== m_adr_bus()) $display("FAIL rnd_adr a=%h: got %h want %h", a, PMPAdr, m_adr_bus()); else passed++;
    end
    bus.CSRReadM = 1'b0;
    bus.CSRWriteM = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus.CSRReadM     = 1'b0;
    bus.CSRWriteM    = 1'b0;
    bus.CSRAdrM      = '0;
    bus.CSRWriteValM = '0;
    m_changed        = 0;
    m_reset();
    test_reset();
    test_addr_write();
    test_cfg_warl();
    test_lock_tor();
    test_illegal();
    test_addr_mask_rbw();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pmp_csr_bank.md
Name: pmp_csr_bank

Overview:
- Holds the PMP configuration state: PMP_ENTRIES pmpcfg bytes and PMP_ENTRIES pmpaddr registers, written and read through the privileged CSR port.
- Applies the WARL and lock rules to every write.
- Drives the flattened PMPCfg/PMPAdr buses that feed the per-entry address decoders and the PMP checker directly downstream.
- Pulses PMPUpdatedM so TLB/ITLB can flush stale permission state.

Parameters:
- XLEN, 64, register width; legal values 32 or 64.
- PA_BITS, 56, physical address width; stored pmpaddr width is PA_BITS-2, which must be <= XLEN.
- PMP_ENTRIES, 16, number of implemented entries; legal values 0, 16, 64.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- CSRReadM  in  1  CSR read strobe
- CSRWriteM  in  1  CSR write strobe; commits on the rising clk edge
- CSRAdrM  in  12  CSR address
- CSRWriteValM  in  XLEN  write data, already merged for set/clear variants
- CSRReadValM  out  XLEN  read data, combinational from current state
- IllegalAccessM  out  1  combinational; accessed address is an illegal PMP CSR
- PMPCfg  out  8*PMP_ENTRIES  entry i occupies bits [8i+7:8i]
- PMPAdr  out  XLEN*PMP_ENTRIES  entry i occupies bits [XLEN*i+XLEN-1:XLEN*i]; bits above PA_BITS-3 are 0
- PMPUpdatedM  out  1  one-cycle pulse after a write that changed any stored bit

Behaviour:
- Reset (asynchronous, any cycle, including mid-write):
  - all cfg bytes = 0x00, all addr = 0, PMPUpdatedM = 0.
  - A write coincident with reset is lost.
- Address map:
  - pmpcfgK at 0x3A0+K, K = 0..15.
  - pmpaddrI at 0x3B0+I, I = 0..63.
- pmpcfgK contents:
  - RV32: pmpcfgK holds entries 4K..4K+3, byte j at bits [8j+7:8j].
  - RV64: only even K is legal; pmpcfgK holds entries 4K..4K+7.
- IllegalAccessM = 1 when (CSRReadM | CSRWriteM) & XLEN==64 & CSRAdrM selects an odd pmpcfg. In that case the write is ignored and CSRReadValM = 0.
- Unimplemented entries (index >= PMP_ENTRIES) inside the map: read 0, writes ignored, not illegal.
- Read: CSRReadValM reflects state before any same-cycle write (read-before-write). pmpaddr reads zero-extend the stored PA_BITS-2 bits.
- Write latency: the new value appears on PMPCfg/PMPAdr the cycle after CSRWriteM. PMPUpdatedM is high in that same cycle only.
- Cfg byte WARL, evaluated per byte:
  - Bits 6:5 are stored as 0.
  - If the new byte has R=0 and W=1 (reserved), the whole byte retains its old value.
- Lock rules, evaluated on pre-write state:
  - cfg byte i is ignored when cfg[i].L=1; the other bytes in the same CSR still update.
  - pmpaddr i is ignored when cfg[i].L=1, or when i+1 < PMP_ENTRIES & cfg[i+1].L=1 & cfg[i+1].A==TOR.
  - L clears only on reset.
- Setting L and A=TOR in one write takes effect next cycle. It does not block a pmpaddr write in that same cycle, because there is only one CSR write per cycle.
- PMP_ENTRIES=0: all PMP CSRs read 0, writes ignored, PMPUpdatedM never asserts.
- Writes whose every byte is ignored or unchanged do not pulse PMPUpdatedM.

Decomposition:
- Package pmp_pkg:
  - PMPCFG_BASE = 12'h3A0 and PMPADDR_BASE = 12'h3B0.
  - A-field encodings OFF=0, TOR=1, NA4=2, NAPOT=3.
  - cfg bit positions L=7, A=4:3, X=2, W=1, R=0.
- Sub-module pmp_entry_reg, instantiated by a generate loop:
  - Contents: one cfg byte, one addr register, and the WARL/lock gating for that entry.
  - Inputs: cfg write enable, addr write enable, the new byte, the new addr, and NextLockedTOR from entry i+1.
  - Outputs: cfg, addr, and a changed flag.
- Top level: address decode, read mux, illegal-access detect, and the PMPUpdatedM flop (OR of changed flags).

Test Plan:
1. Reset mid-operation, then write pmpaddr3 = 0x1000 -> next cycle PMPAdr entry3 = 0x1000 and PMPUpdatedM = 1 for one cycle. Assert reset mid-test -> all outputs 0 immediately.
2. Write pmpcfg0 = 0x0000_0000_8F00_0F1F (XLEN=64) -> byte1 stored 0x0F; byte3 stored 0x8F (locked); byte0 = 0x1F. Rewrite pmpcfg0 = 0 -> byte3 stays 0x8F, others 0.
3. Set cfg[5] = 0x89 (L, TOR), then write pmpaddr4 = 0xABC -> pmpaddr4 unchanged, no PMPUpdatedM pulse. Write pmpaddr6 = 0xABC -> accepted.
4. Write cfg byte value 0x62 (R=0, W=1, bits 6:5 set) -> byte unchanged. Write 0x63 -> stored 0x03.
5. XLEN=64: read/write 0x3A1 -> IllegalAccessM = 1, CSRReadValM = 0, state unchanged. Access 0x3EF with PMP_ENTRIES=16 -> reads 0, IllegalAccessM = 0.
6. Write pmpaddr0 = all-ones -> reads back with bits [XLEN-1:PA_BITS-2] = 0. Same-cycle read of pmpaddr0 returns the old value.
